// File: rtl/tri_stream_tx.sv
// rtl/tri_stream_tx.sv - broadcasts 10-word triangle records to a bus of raster cores
//
// Purpose: accepts one triangle record (or a frame-end command) at a time,
// latches it, and broadcasts it word by word. A word moves only when every
// participating core is ready.
//
// Optional feature: define TRI_STREAM_TX_CULL_EN to drop non-end records
// whose header start field exceeds its end field. A dropped record is still
// accepted, but it is not transmitted.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   in_valid/in_ready    record handshake
//   in_words             10 x LWIDTH record, word k at [k*LWIDTH +: LWIDTH]
//   in_end, in_flush     frame-end command, with optional BRAM flush request
//   core_ready/core_mask per-core ready and participation mask
//   out_data/out_valid   broadcast word and its valid flag
//   out_last             marks word 9
//   out_handshake        transfer strobe seen by all cores
//   tri_count            triangles sent (end commands excluded), wraps at 16 bits
module tri_stream_tx #(
  parameter int NUM_CORES = 32,
  parameter int LWIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [10*LWIDTH-1:0]  in_words,
  input  logic                  in_end,
  input  logic                  in_flush,
  input  logic [NUM_CORES-1:0]  core_ready,
  input  logic [NUM_CORES-1:0]  core_mask,
  output logic [LWIDTH-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_handshake,
  output logic [15:0]           tri_count
);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t            state;
  logic [3:0]        index;
  logic              is_end;
  logic [LWIDTH-1:0] words_q [10];
  logic [LWIDTH-1:0] end_hdr;
  logic              accept;
  logic              cull;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // A masked-out core never holds the bus, so an all-zero mask handshakes on every valid cycle.
  assign out_handshake = out_valid & (&(core_ready | ~core_mask));
  assign out_data      = words_q[index];

  always_comb begin
    end_hdr       = '0;
    end_hdr[11:0] = {(in_flush ? 6'h3F : 6'h00), 6'h3F};
  end

`ifdef TRI_STREAM_TX_CULL_EN
  // An empty header range means nothing to rasterise, so the record is swallowed here.
  assign cull = ~in_end & (in_words[5:0] > in_words[11:6]);
`else
  assign cull = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      index     <= 4'd0;
      is_end    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      tri_count <= 16'h0000;
      for (int k = 0; k < 10; k++) words_q[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !cull) begin
            for (int k = 0; k < 10; k++) begin
              if (in_end) words_q[k] <= (k == 0) ? end_hdr : '0;
              else        words_q[k] <= in_words[k*LWIDTH +: LWIDTH];
            end
            is_end    <= in_end;
            index     <= 4'd0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_handshake) begin
            if (index == 4'd9) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              index     <= 4'd0;
              state     <= IDLE;
              if (!is_end) tri_count <= tri_count + 16'd1;
            end else begin
              index    <= index + 4'd1;
              // Registered copy of (index == 9) while valid.
              out_last <= (index == 4'd8);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_stream_tx.sv
// tb/tb_tri_stream_tx.sv - directed self-checking bench for tri_stream_tx
module tb_tri_stream_tx;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [319:0] in_words = '0;
  logic         in_end = 1'b0;
  logic         in_flush = 1'b0;
  logic [31:0]  core_ready = '1;
  logic [31:0]  core_mask = '1;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_handshake;
  logic [15:0]  tri_count;

  int           checks = 0;
  int           failures = 0;
  logic [15:0]  exp_tri = 16'h0000;
  logic [31:0]  got_data [10];
  logic         got_last [10];
  int           got_n;

  tri_stream_tx #(.NUM_CORES(32), .LWIDTH(32)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .in_words(in_words), .in_end(in_end), .in_flush(in_flush),
    .core_ready(core_ready), .core_mask(core_mask), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_handshake(out_handshake),
    .tri_count(tri_count)
  );

  always #5 clk = ~clk;

  function automatic logic [319:0] mkrec(input logic [31:0] base);
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one record and holds it until accepted; leaves the bench at posedge+1.
  task automatic accept_rec(input logic [319:0] w, input logic e, input logic f);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%0d required=1", in_ready);
    end
    in_valid = 1'b1;
    in_words = w;
    in_end   = e;
    in_flush = f;
    tick();
    in_valid = 1'b0;
    in_end   = 1'b0;
    in_flush = 1'b0;
  endtask

  // Records the words transferred by up to ten handshakes.
  task automatic collect();
    got_n = 0;
    for (int c = 0; c < 80 && got_n < 10; c++) begin
      @(negedge clk);
      if (out_handshake) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_n++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0d required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0d required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %0d required 0", out_last); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++; if (tri_count !== 16'h0) begin failures++; $display("FAIL reset_tri_count: got %h required 0", tri_count); end
  endtask

  task automatic test_basic(input logic [31:0] base);
    accept_rec(mkrec(base), 1'b0, 1'b0);
    collect();
    exp_tri = exp_tri + 16'd1;
    checks++; if (got_n !== 10) begin failures++; $display("FAIL basic_count: got %0d required 10", got_n); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got_data[k] !== base + 32'(k)) begin failures++; $display("FAIL basic_data[%0d]: got %h required %h", k, got_data[k], base + 32'(k)); end
      checks++; if (got_last[k] !== (k == 9)) begin failures++; $display("FAIL basic_last[%0d]: got %0d required %0d", k, got_last[k], (k == 9)); end
    end
    checks++; if (tri_count !== exp_tri) begin failures++; $display("FAIL basic_tri_count: got %h required %h", tri_count, exp_tri); end
  endtask

  task automatic test_stall();
    accept_rec(mkrec(32'h100), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (out_handshake !== 1'b1 || out_data !== 32'h100 + 32'(k)) begin failures++; $display("FAIL stall_pre[%0d]: got hs=%0d data=%h required hs=1 data=%h", k, out_handshake, out_data, 32'h100 + 32'(k)); end
    end
    tick();
    core_ready[5] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_handshake !== 1'b0 || out_data !== 32'h104) begin failures++; $display("FAIL stall_hold[%0d]: got v=%0d hs=%0d data=%h required v=1 hs=0 data=00000104", c, out_valid, out_handshake, out_data); end
    end
    tick();
    core_ready[5] = 1'b1;
    for (int k = 4; k < 10; k++) begin
      @(negedge clk);
      checks++; if (out_handshake !== 1'b1 || out_data !== 32'h100 + 32'(k)) begin failures++; $display("FAIL stall_post[%0d]: got hs=%0d data=%h required hs=1 data=%h", k, out_handshake, out_data, 32'h100 + 32'(k)); end
    end
    tick();
    exp_tri = exp_tri + 16'd1;
    checks++; if (tri_count !== exp_tri) begin failures++; $display("FAIL stall_tri_count: got %h required %h", tri_count, exp_tri); end
  endtask

  task automatic test_mask();
    core_mask[5]  = 1'b0;
    core_ready[5] = 1'b0;
    accept_rec(mkrec(32'h200), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (out_handshake !== 1'b1 || out_data !== 32'h200 + 32'(k)) begin failures++; $display("FAIL mask_word[%0d]: got hs=%0d data=%h required hs=1 data=%h", k, out_handshake, out_data, 32'h200 + 32'(k)); end
    end
    tick();
    core_mask  = '1;
    core_ready = '1;
    exp_tri = exp_tri + 16'd1;
    checks++; if (tri_count !== exp_tri) begin failures++; $display("FAIL mask_tri_count: got %h required %h", tri_count, exp_tri); end
  endtask

  task automatic test_end(input logic f, input logic [31:0] hdr);
    accept_rec(mkrec(32'h1234_0000), 1'b1, f);
    collect();
    checks++; if (got_n !== 10) begin failures++; $display("FAIL end_count: got %0d required 10", got_n); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got_data[k] !== ((k == 0) ? hdr : 32'h0)) begin failures++; $display("FAIL end_word[%0d] flush=%0d: got %h required %h", k, f, got_data[k], (k == 0) ? hdr : 32'h0); end
    end
    checks++; if (tri_count !== exp_tri) begin failures++; $display("FAIL end_tri_count: got %h required %h", tri_count, exp_tri); end
  endtask

  task automatic test_back_to_back();
    logic [319:0] ra;
    logic [319:0] rb;
    ra = mkrec(32'h300);
    rb = mkrec(32'h400);
    in_valid = 1'b1;
    in_words = ra;
    tick();
    in_words = rb;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 11) begin
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap: got v=%0d rdy=%0d required v=0 rdy=1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
      end else begin
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ((c < 11) ? 32'h300 + 32'(c - 1) : 32'h400 + 32'(c - 12))) begin
          failures++;
          $display("FAIL b2b_cycle[%0d]: got v=%0d rdy=%0d data=%h required v=1 rdy=0 data=%h", c, out_valid, in_ready, out_data, (c < 11) ? 32'h300 + 32'(c - 1) : 32'h400 + 32'(c - 12));
        end
      end
    end
    tick();
    exp_tri = exp_tri + 16'd2;
    checks++; if (tri_count !== exp_tri) begin failures++; $display("FAIL b2b_tri_count: got %h required %h", tri_count, exp_tri); end
  endtask

  task automatic test_reset_mid();
    accept_rec(mkrec(32'h500), 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    tick();
    checks++; if (out_data !== 32'h506) begin failures++; $display("FAIL rmid_at_word6: got %h required 00000506", out_data); end
    nreset = 1'b0;
    #1;
    exp_tri = 16'h0;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rmid_async: got v=%0d last=%0d required 0 0", out_valid, out_last); end
    checks++; if (tri_count !== 16'h0) begin failures++; $display("FAIL rmid_tri_count: got %h required 0", tri_count); end
    @(negedge clk);
    nreset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rmid_release: got rdy=%0d v=%0d required 1 0", in_ready, out_valid); end
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_resume: got v=%0d required 0", out_valid); end
    test_basic(32'h80);
  endtask

  task automatic test_cull();
    logic [319:0] r;
    r = mkrec(32'h600);
    r[31:0] = 32'h0000_0005;
    accept_rec(r, 1'b0, 1'b0);
`ifdef TRI_STREAM_TX_CULL_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL cull_idle[%0d]: got v=%0d rdy=%0d required 0 1", c, out_valid, in_ready); end
    end
    tick();
`else
    collect();
    exp_tri = exp_tri + 16'd1;
    checks++; if (got_n !== 10 || got_data[0] !== 32'h5 || got_data[9] !== 32'h609) begin failures++; $display("FAIL cull_sent: got n=%0d w0=%h w9=%h required 10 00000005 00000609", got_n, got_data[0], got_data[9]); end
`endif
    checks++; if (tri_count !== exp_tri) begin failures++; $display("FAIL cull_tri_count: got %h required %h", tri_count, exp_tri); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.tri_count = 16'hFFFF;
    #1;
    release dut.tri_count;
    tick();
    checks++; if (tri_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset: got %h required ffff", tri_count); end
    exp_tri = 16'hFFFF;
    test_basic(32'h700);
    checks++; if (tri_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h required 0000", tri_count); end
  endtask

  initial begin
    test_reset();
    test_basic(32'h40);
    test_stall();
    test_mask();
    test_end(1'b1, 32'h0000_0FFF);
    test_end(1'b0, 32'h0000_003F);
    test_back_to_back();
    test_reset_mid();
    test_cull();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_stream_tx.md
TRI_STREAM_TX -- requirements
Module: tri_stream_tx

Interface
REQ-001 Parameter NUM_CORES, default 32: number of raster cores on the broadcast bus.
REQ-002 Parameter LWIDTH, default 32: stream word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  triangle record valid.
REQ-006 in_ready  output  1  block can accept a record.
REQ-007 in_words  input  10*LWIDTH  record; word k at bits [32k+31:32k], k=0 header, 1-2 lambda zero, 3-6 lambda diffs, 7 z zero, 8-9 z diffs.
REQ-008 in_end  input  1  record is a frame-end command; in_words ignored.
REQ-009 in_flush  input  1  with in_end: request BRAM flush instead of writeback-only end.
REQ-010 core_ready  input  NUM_CORES  per-core ready.
REQ-011 core_mask  input  NUM_CORES  1 = core participates; 0 = ignored.
REQ-012 out_data  output  LWIDTH  broadcast word.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_last  output  1  high with word 9.
REQ-015 out_handshake  output  1  broadcast transfer strobe to all cores.
REQ-016 tri_count  output  16  triangles sent, end commands excluded.

Function
REQ-017 States: IDLE and SEND; in_ready = (state == IDLE).
REQ-018 IDLE: in_valid & in_ready latches the record into a 10-word register and enters SEND with word index 0; out_valid rises next cycle.
REQ-019 On in_end, latched words: word 0 = {20'h0, flush ? 6'h3F : 6'h00, 6'h3F}; words 1-9 = 0.
REQ-020 out_handshake = out_valid & AND over all i of (core_ready[i] | ~core_mask[i]); combinational.
REQ-021 core_mask all zero: every out_valid cycle is a handshake.
REQ-022 out_data = latched word[index]; stable while out_valid and not out_handshake.
REQ-023 Each out_handshake advances the index by 1; at index 9, out_valid and out_last drop next cycle and state returns to IDLE.
REQ-024 out_last = out_valid & (index == 9).
REQ-025 Back-to-back: new record accepted no earlier than the cycle after return to IDLE; minimum packet period 11 cycles.
REQ-026 Ready drop: cores deasserting ready after word 9 of the previous packet stall word 0 of the next until they reassert; no word is sent to a masked-in core that is not ready.
REQ-027 tri_count increments on word-9 handshake of a non-end packet; 16-bit wrap 0xFFFF -> 0x0000.
REQ-028 in_valid ignored while in SEND; in_words and in_end sampled only at acceptance.
REQ-029 core_mask changes mid-packet take effect the same cycle.

Reset
REQ-030 nreset low asynchronously forces state IDLE, index 0, out_valid 0, out_last 0, out_data 0, tri_count 0, record registers 0.
REQ-031 Reset mid-packet aborts it; no partial packet resumes after release.
REQ-032 in_ready = 1 in the first cycle after release.

Configuration
REQ-033 Macro TRI_STREAM_TX_CULL_EN.
REQ-034 Defined: a non-end record with in_words[5:0] > in_words[11:6] is accepted (in_ready handshake completes), not transmitted, and leaves tri_count unchanged; state stays IDLE.
REQ-035 Undefined: all records are transmitted regardless of header range.

Verification
REQ-036 Record words 0x00000040+k, mask all ones, core_ready all ones -> ten handshakes, data 0x40..0x49 in order, out_last only on 0x49, tri_count = 1.
REQ-037 core_ready[5] low for 3 cycles at word 4 -> out_data held at word 4 for 3 cycles; no handshake; then resumes; with core_mask[5] = 0 -> no stall.
REQ-038 in_end = 1, in_flush = 1 -> word 0 = 0x00000FFF, words 1-9 = 0; in_flush = 0 -> word 0 = 0x0000003F; tri_count unchanged.
REQ-039 nreset pulsed low at word 6 -> out_valid low immediately, in_ready high after release, next record starts at word 0.
REQ-040 tri_count preset via 65535 packets -> next packet wraps tri_count to 0.
REQ-041 TRI_STREAM_TX_CULL_EN defined, header 0x00000005 (start 5, end 0) -> no out_valid, tri_count unchanged; undefined -> transmitted normally.
